cnu_ms_serial: RTL
==================

CNU_MS_SERIAL -- requirements
Module: cnu_ms_serial

Interface
REQ-001 SHALL have parameter DATA_W, default 8: two's-complement message width.
REQ-002 SHALL have parameter DMAX, default 32: maximum row degree (buffered signs).
REQ-003 SHALL have parameter IDX_W, default 5: beat index width; 2^IDX_W >= DMAX.
REQ-004 SHALL have port clk  input  1: the single clock, rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports in_valid  input  1; in_ready  output  1: input handshake.
REQ-007 SHALL have ports in_q  input  DATA_W: variable-to-check message; in_last  input  1: final beat of row.
REQ-008 SHALL have ports mode  input  2: 0 plain min-sum, 1 normalized x3/4, 2 offset, 3 treated as 0; offset  input  DATA_W-1: offset magnitude.
REQ-009 SHALL have ports out_valid  output  1; out_ready  input  1: output handshake.
REQ-010 SHALL have ports out_r  output  DATA_W: check-to-variable message; out_last  output  1: final output beat of row.
REQ-011 SHALL have port err  output  1: one-cycle pulse on degree overflow.

Function
REQ-012 SHALL have two states: COLLECT (in_ready=1, out_valid=0) and EMIT (in_ready=0).
REQ-013 SHALL accept a beat only when in_valid&in_ready; out beat transfers only on out_valid&out_ready.
REQ-014 SHALL sample mode and offset on the first accepted beat of a row and hold them for the row.
REQ-015 SHALL compute mag = |in_q|, saturating -2^(DATA_W-1) to 2^(DATA_W-1)-1; sign = MSB; zero is positive.
REQ-016 SHALL initialise min and min2 to 2^(DATA_W-1)-1 at row start; on each beat: if mag<min then min2<=min, min<=mag, idx<=beat index; else if mag<min2 then min2<=mag.
REQ-017 SHALL keep idx at the first occurrence on ties; an equal value loads min2.
REQ-018 SHALL store each beat's sign at its beat index and accumulate parity = XOR of all signs.
REQ-019 SHALL record degree = beats accepted; leave COLLECT on in_last or on the DMAX-th beat, whichever is first.
REQ-020 SHALL pulse err for one cycle when the DMAX-th beat is accepted with in_last=0; the row closes at DMAX.
REQ-021 SHALL present output beat 0 on the cycle after the closing input beat is accepted (latency 1).
REQ-022 SHALL output, for beat i, m = (i==idx) ? min2 : min, then f(m): mode0 m; mode1 (3m)>>2 computed in DATA_W+1 bits; mode2 max(m-offset,0).
REQ-023 SHALL negate f(m) when parity XOR sign[i] = 1; the result always fits DATA_W.
REQ-024 SHALL hold out_r, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL assert out_last on beat degree-1 only; a degree-1 row outputs f(2^(DATA_W-1)-1) with sign parity XOR sign[0] = 0.
REQ-026 SHALL return to COLLECT after the out_last transfer, with in_ready=1 the next cycle and min/min2/parity reinitialised.

Reset
REQ-027 SHALL, while rst=0, asynchronously force state COLLECT, in_ready=1, out_valid=0, out_r=0, out_last=0, err=0, min=min2=2^(DATA_W-1)-1, parity=0, counters=0.
REQ-028 SHALL discard any partial row or pending output on reset; the first beat after release starts a new row.

Structure
REQ-029 SHALL place mode encodings (MODE_PLAIN, MODE_NORM, MODE_OFFS) and the magnitude-max constant in shared package cnu_pkg.
REQ-030 SHALL reuse the existing abs block for magnitude/sign extraction.
REQ-031 SHALL implement f() in one combinational sub-module cnu_norm (inputs m, mode, offset; output f).

Verification
REQ-032 Row [5,-3,7,-2], last on beat 3, mode1 -> out_r [1,-1,1,-2], out_last on beat 3.
REQ-033 Same row, mode0 -> [2,-2,2,-3]; mode2 offset=1 -> [1,-1,1,-2].
REQ-034 Single beat -128 with last, mode0 -> out_r +127, out_last=1.
REQ-035 DMAX=4, five beats [1,2,3,4,5], no last -> err pulse on beat 4; outputs [2,1,1,1] (mode0); beat 5 starts a new row.
REQ-036 Row [4,4,9], mode0, out_ready low 3 cycles at beat 1 -> out_r holds 4; idx=0; sequence [4,4,4].
REQ-037 rst low during EMIT beat 1 -> out_valid=0 immediately, in_ready=1; next row outputs correct values.

Source files
------------

// File: rtl/cnu_pkg.sv
// Shared definitions for the serial min-sum check-node unit.
// Holds the mode encodings, the FSM state type and the saturated
// magnitude maximum, which depends on the message width.
package cnu_pkg;

  localparam logic [1:0] MODE_PLAIN = 2'd0;
  localparam logic [1:0] MODE_NORM  = 2'd1;
  localparam logic [1:0] MODE_OFFS  = 2'd2;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } cnu_state_t;

  // Largest magnitude representable in a w-bit two's-complement message.
  function automatic int mag_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/cnu_abs.sv
// Magnitude/sign extraction for a two's-complement message.
// Ports:
//   d    - input message
//   mag  - |d|, with the most negative code saturated to the max magnitude
//   sign - MSB of d (zero counts as positive)
module cnu_abs
  import cnu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] mag,
  output logic              sign
);

  localparam logic [DATA_W-1:0] MAG_MAX  = DATA_W'(mag_max(DATA_W));
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  always_comb begin
    sign = d[DATA_W-1];
    if (!sign)
      mag = d;
    else if (d == MOST_NEG)
      mag = MAG_MAX;
    else
      mag = -d;
  end

endmodule

// File: rtl/cnu_norm.sv
// Output scaling for the check-node message magnitude.
// Ports:
//   m      - non-negative magnitude selected for this output beat
//   mode   - plain / normalized x3/4 / offset (code 3 behaves as plain)
//   offset - offset magnitude used in offset mode
//   f      - scaled magnitude, never negative
module cnu_norm
  import cnu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] m,
  input  logic [1:0]        mode,
  input  logic [DATA_W-2:0] offset,
  output logic [DATA_W-1:0] f
);

  logic [DATA_W:0]   m3;
  logic [DATA_W-1:0] offs_ext;

  always_comb begin
    // 3m needs one extra bit before the divide by 4
    m3       = {1'b0, m} + {m, 1'b0};
    offs_ext = {1'b0, offset};
    f        = m;
    case (mode)
      MODE_NORM: f = DATA_W'(m3 >> 2);
      MODE_OFFS: f = (m > offs_ext) ? (m - offs_ext) : '0;
      default:   f = m;
    endcase
  end

endmodule

// File: rtl/cnu_ms_serial.sv
// Serial min-sum check-node unit. Collects one row of variable-to-check
// messages beat by beat, tracking the two smallest magnitudes, the index
// of the smallest and the sign parity, then streams the check-to-variable
// messages back out in the same beat order.
// Ports:
//   clk, rst                  - clock, async active-low reset
//   in_valid/in_ready         - input handshake; in_q message, in_last row end
//   mode, offset              - scaling selection, sampled on a row's first beat
//   out_valid/out_ready       - output handshake; out_r message, out_last row end
//   err                       - one-cycle pulse when a row hits DMAX without in_last
//
// state      | meaning
// ST_COLLECT | accepting input beats, updating min/min2/idx/parity/signs
// ST_EMIT    | presenting output beats 0..degree-1, inputs stalled
module cnu_ms_serial
  import cnu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DMAX   = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_q,
  input  logic              in_last,
  input  logic [1:0]        mode,
  input  logic [DATA_W-2:0] offset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic              out_last,
  output logic              err
);

  localparam logic [DATA_W-1:0] MAG_MAX  = DATA_W'(mag_max(DATA_W));
  localparam logic [IDX_W:0]    LAST_CNT = (IDX_W+1)'(DMAX - 1);
  localparam logic [IDX_W:0]    ONE      = (IDX_W+1)'(1);

  cnu_state_t        state_q, state_d;
  logic [IDX_W:0]    cnt_q;
  logic [IDX_W:0]    degree_q;
  logic [IDX_W:0]    out_i_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] min_q, min2_q;
  logic              parity_q;
  logic [DMAX-1:0]   signs_q;
  logic [1:0]        mode_q;
  logic [DATA_W-2:0] offset_q;
  logic              err_q;

  logic [DATA_W-1:0] mag;
  logic              sign;
  logic              accept, xfer, closing;
  logic [DATA_W-1:0] m_sel, f_val;
  logic              neg;

  cnu_abs #(.DATA_W(DATA_W)) u_abs (
    .d    (in_q),
    .mag  (mag),
    .sign (sign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_COLLECT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    closing   = in_last || (cnt_q == LAST_CNT);
    case (state_q)
      ST_COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && closing) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        out_last  = (out_i_q + ONE) == degree_q;
        xfer      = out_ready;
        if (xfer && out_last) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      degree_q <= '0;
      out_i_q  <= '0;
      idx_q    <= '0;
      min_q    <= MAG_MAX;
      min2_q   <= MAG_MAX;
      parity_q <= 1'b0;
      signs_q  <= '0;
      mode_q   <= MODE_PLAIN;
      offset_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && (cnt_q == LAST_CNT) && !in_last;
      if (accept) begin
        if (cnt_q == '0) begin
          mode_q   <= mode;
          offset_q <= offset;
        end
        signs_q[cnt_q[IDX_W-1:0]] <= sign;
        parity_q <= parity_q ^ sign;
        // strict compare keeps idx at the first minimum; a tie lands in min2
        if (mag < min_q) begin
          min2_q <= min_q;
          min_q  <= mag;
          idx_q  <= cnt_q[IDX_W-1:0];
        end else if (mag < min2_q) begin
          min2_q <= mag;
        end
        if (closing) begin
          degree_q <= cnt_q + ONE;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + ONE;
        end
      end
      if (xfer) begin
        if (out_last) begin
          out_i_q  <= '0;
          idx_q    <= '0;
          min_q    <= MAG_MAX;
          min2_q   <= MAG_MAX;
          parity_q <= 1'b0;
        end else begin
          out_i_q <= out_i_q + ONE;
        end
      end
    end
  end

  // Outputs are decoded from registered row state, so they stay put under
  // backpressure and drop to zero as soon as reset returns us to COLLECT.
  assign m_sel = ({1'b0, idx_q} == out_i_q) ? min2_q : min_q;

  cnu_norm #(.DATA_W(DATA_W)) u_norm (
    .m      (m_sel),
    .mode   (mode_q),
    .offset (offset_q),
    .f      (f_val)
  );

  assign neg   = parity_q ^ signs_q[out_i_q[IDX_W-1:0]];
  assign out_r = (state_q == ST_EMIT) ? (neg ? -f_val : f_val) : '0;
  assign err   = err_q;

endmodule
